// File: rtl/cla_serial_adder_pkg.sv
// Shared constants for the multi-cycle carry-lookahead adder: group width,
// state encoding and the group-index width helper.
package cla_serial_adder_pkg;

  localparam int unsigned GRP_W = 4;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // A lone group still needs a one-bit index register.
  function automatic int unsigned idx_width(input int unsigned ngrp);
    return (ngrp > 1) ? $clog2(ngrp) : 1;
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice: bit and group generate/propagate,
// flat lookahead carries and the sum bits.
module cla_slice4
  import cla_serial_adder_pkg::*;
(
  input  logic [GRP_W-1:0] a,
  input  logic [GRP_W-1:0] b,
  input  logic             c0,
  output logic [GRP_W-1:0] s,
  output logic             G,
  output logic             P,
  output logic             c_out,
  output logic             c3
);

  logic [GRP_W-1:0] g;
  logic [GRP_W-1:0] p;
  logic             c1;
  logic             c2;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a two-level sum of products off c0; nothing ripples.
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

  assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign P = &p;

  assign c_out = G | (P & c0);
  assign s     = p ^ {c3, c2, c1, c0};

endmodule

// File: rtl/cla_serial_adder.sv
// Wide adder/subtractor that reuses one 4-bit lookahead slice, one group per
// clock, carrying the group carry-out in a register between groups.
module cla_serial_adder
  import cla_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int unsigned NGRP = WIDTH / GRP_W;
  localparam int unsigned IDXW = idx_width(NGRP);
  localparam logic [IDXW-1:0] LAST = IDXW'(NGRP - 1);

  if ((WIDTH % GRP_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [GRP_W-1:0] slc_a;
  logic [GRP_W-1:0] slc_b;
  logic [GRP_W-1:0] slc_s;
  logic             slc_g;
  logic             slc_p;
  logic             slc_cout;
  logic             slc_c3;

  assign slc_a = a_q[idx_q*GRP_W +: GRP_W];
  assign slc_b = b_q[idx_q*GRP_W +: GRP_W];

  cla_slice4 u_slice (
    .a     (slc_a),
    .b     (slc_b),
    .c0    (carry_q),
    .s     (slc_s),
    .G     (slc_g),
    .P     (slc_p),
    .c_out (slc_cout),
    .c3    (slc_c3)
  );

  // Group-level G/P must agree with the slice's own carry-out.
  always_comb begin
    if (state_q == RUN) begin
      assert (slc_cout == (slc_g | (slc_p & carry_q)));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1.
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[idx_q*GRP_W +: GRP_W] = slc_s;
        carry_d = slc_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          cout_d  = slc_cout;
          ovf_d   = slc_c3 ^ slc_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign S     = s_q;
  assign Cout  = cout_q;
  assign ovf   = ovf_q;

endmodule
